// File: rtl/dram_arbiter.sv
// Two-port arbiter in front of a single-outstanding DRAM controller request channel.
// Latency: port request seen at an idle edge -> m_valid next cycle; m_ready edge -> port ready next cycle.
// Backpressure: requesters hold valid until their one-cycle ready pulse; one transaction in flight, no queuing.
//
// Ports:
//   clk, reset           - sole clock, synchronous active-high reset
//   p0_* / p1_*          - requester ports: valid/addr/wmask/wdata in, ready pulse and rdata out
//   m_*                  - controller side: registered valid/addr/wmask/wdata out, ready/rdata in
//   busy                 - high while a transaction is in flight or its response is being returned
//   grant                - index of the port currently or most recently served
module dram_arbiter #(
    parameter bit RR = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         p0_valid,
    output logic         p0_ready,
    input  logic [31:0]  p0_addr,
    input  logic         p0_wmask,
    input  logic [127:0] p0_wdata,
    output logic [127:0] p0_rdata,
    input  logic         p1_valid,
    output logic         p1_ready,
    input  logic [31:0]  p1_addr,
    input  logic         p1_wmask,
    input  logic [127:0] p1_wdata,
    output logic [127:0] p1_rdata,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [31:0]  m_addr,
    output logic         m_wmask,
    output logic [127:0] m_wdata,
    input  logic [127:0] m_rdata,
    output logic         busy,
    output logic         grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   winner;
    logic   accept;
    logic   complete;

    // On a tie in round-robin mode the port that was not served last wins;
    // otherwise port 0 wins whenever it asks, and port 1 only when alone.
    always_comb begin
        if (RR && p0_valid && p1_valid) begin
            winner = ~grant;
        end else begin
            winner = ~p0_valid;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (p0_valid || p1_valid) begin
                    state_nxt = ISSUE;
                    accept    = 1'b1;
                end
            end
            ISSUE: begin
                // m_valid is high for the whole of ISSUE, so a stray m_ready
                // in any other state never reaches this branch.
                if (m_valid && m_ready) begin
                    state_nxt = RESP;
                    complete  = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid  <= 1'b0;
            m_addr   <= '0;
            m_wmask  <= 1'b0;
            m_wdata  <= '0;
            grant    <= 1'b1;
            p0_ready <= 1'b0;
            p1_ready <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            p0_ready <= 1'b0;
            p1_ready <= 1'b0;
            if (accept) begin
                // grant doubles as the last-served pointer for round-robin
                m_valid <= 1'b1;
                grant   <= winner;
                m_addr  <= winner ? p1_addr  : p0_addr;
                m_wmask <= winner ? p1_wmask : p0_wmask;
                m_wdata <= winner ? p1_wdata : p0_wdata;
            end
            if (complete) begin
                // rdata is captured on writes too; the controller's data is
                // simply passed through whatever it is.
                m_valid <= 1'b0;
                if (grant) begin
                    p1_ready <= 1'b1;
                    p1_rdata <= m_rdata;
                end else begin
                    p0_ready <= 1'b1;
                    p0_rdata <= m_rdata;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: runs a fixed-priority (rr0) and a round-robin (rr1) instance side by side.
// Each cycle the outputs are compared with a transaction-level model derived from the arbitration rules.
// Requesters and a DRAM responder with random delays and stray m_ready pulses generate the stimulus.
module tb_dram_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         pv  [2][2];
    logic         pr  [2][2];
    logic [31:0]  pa  [2][2];
    logic         pw  [2][2];
    logic [127:0] pd  [2][2];
    logic [127:0] prd [2][2];
    logic         mv  [2];
    logic         mr  [2];
    logic [31:0]  ma  [2];
    logic         mw  [2];
    logic [127:0] md  [2];
    logic [127:0] mrd [2];
    logic         bsy [2];
    logic         gnt [2];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        dram_arbiter #(.RR(k == 1)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .p0_valid (pv[k][0]),
            .p0_ready (pr[k][0]),
            .p0_addr  (pa[k][0]),
            .p0_wmask (pw[k][0]),
            .p0_wdata (pd[k][0]),
            .p0_rdata (prd[k][0]),
            .p1_valid (pv[k][1]),
            .p1_ready (pr[k][1]),
            .p1_addr  (pa[k][1]),
            .p1_wmask (pw[k][1]),
            .p1_wdata (pd[k][1]),
            .p1_rdata (prd[k][1]),
            .m_valid  (mv[k]),
            .m_ready  (mr[k]),
            .m_addr   (ma[k]),
            .m_wmask  (mw[k]),
            .m_wdata  (md[k]),
            .m_rdata  (mrd[k]),
            .busy     (bsy[k]),
            .grant    (gnt[k])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: an in-flight transaction, a response cycle, last-served port.
    logic         mdl_out  [2];
    logic         mdl_resp [2];
    logic         mdl_last [2];
    int           mdl_own  [2];
    logic [31:0]  mdl_a    [2];
    logic         mdl_w    [2];
    logic [127:0] mdl_d    [2];
    logic [127:0] mdl_rd   [2][2];

    // Stimulus state and knobs.
    logic [127:0] mem [2][64];
    int  dly [2];
    int  dly_min = 0;
    int  dly_max = 4;
    int  stray_pct = 0;
    int  rst_pct = 0;
    bit  auto_req = 0;
    int  req_pct [2];
    bit  immed [2];
    bit  rq_done [2][2];
    int  ready_cnt [2][2];
    int  ord [2][8];
    int  ord_n [2];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int exp_winner(int k, logic v0, logic v1, logic last);
        if (v0 && v1) return (k == 1) ? int'(!last) : 0;
        return v0 ? 0 : 1;
    endfunction

    task automatic new_req(input int k, input int p);
        pv[k][p] = 1'b1;
        pa[k][p] = {22'h0, 6'($urandom_range(63)), 4'h0};
        pw[k][p] = 1'($urandom_range(1));
        pd[k][p] = rnd128();
    endtask

    task automatic step();
        logic         s_v   [2][2];
        logic [31:0]  s_a   [2][2];
        logic         s_w   [2][2];
        logic [127:0] s_d   [2][2];
        logic         s_mr  [2];
        logic [127:0] s_mrd [2];
        logic         s_rst;
        s_v   = pv;
        s_a   = pa;
        s_w   = pw;
        s_d   = pd;
        s_mr  = mr;
        s_mrd = mrd;
        s_rst = reset;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            string t;
            t = $sformatf("rr%0d", k);
            if (s_rst) begin
                mdl_out[k]   = 1'b0;
                mdl_resp[k]  = 1'b0;
                mdl_last[k]  = 1'b1;
                mdl_a[k]     = '0;
                mdl_w[k]     = 1'b0;
                mdl_d[k]     = '0;
                mdl_rd[k][0] = '0;
                mdl_rd[k][1] = '0;
            end else if (mdl_resp[k]) begin
                mdl_resp[k] = 1'b0;
            end else if (mdl_out[k]) begin
                if (s_mr[k]) begin
                    mdl_out[k]  = 1'b0;
                    mdl_resp[k] = 1'b1;
                    mdl_rd[k][mdl_own[k]] = s_mrd[k];
                end
            end else if (s_v[k][0] || s_v[k][1]) begin
                mdl_own[k]  = exp_winner(k, s_v[k][0], s_v[k][1], mdl_last[k]);
                mdl_last[k] = mdl_own[k][0];
                mdl_out[k]  = 1'b1;
                mdl_a[k]    = s_a[k][mdl_own[k]];
                mdl_w[k]    = s_w[k][mdl_own[k]];
                mdl_d[k]    = s_d[k][mdl_own[k]];
            end
            chk({t, ".m_valid"}, mv[k], mdl_out[k]);
            chk({t, ".busy"}, bsy[k], mdl_out[k] | mdl_resp[k]);
            chk({t, ".grant"}, gnt[k], mdl_last[k]);
            chk({t, ".m_addr"}, ma[k], mdl_a[k]);
            chk({t, ".m_wmask"}, mw[k], mdl_w[k]);
            chk({t, ".m_wdata"}, md[k], mdl_d[k]);
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("%s.p%0d_ready", t, p), pr[k][p], mdl_resp[k] && (mdl_own[k] == p));
                chk($sformatf("%s.p%0d_rdata", t, p), prd[k][p], mdl_rd[k][p]);
            end
        end
        // DRAM responder
        for (int k = 0; k < 2; k++) begin
            if (mv[k]) begin
                if (dly[k] <= 0) begin
                    mr[k] = 1'b1;
                    if (mdl_w[k]) begin
                        mem[k][mdl_a[k][9:4]] = mdl_d[k];
                        mrd[k] = rnd128();
                    end else begin
                        mrd[k] = mem[k][mdl_a[k][9:4]];
                    end
                end else begin
                    dly[k]--;
                    mr[k]  = 1'b0;
                    mrd[k] = rnd128();
                end
            end else begin
                dly[k] = int'($urandom_range(dly_max, dly_min));
                mr[k]  = (int'($urandom_range(99)) < stray_pct);
                mrd[k] = rnd128();
            end
        end
        // Requesters: keep valid through the ready cycle, drop it one cycle later.
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (pr[k][p]) begin
                    ready_cnt[k][p]++;
                    if (ord_n[k] < 8) begin
                        ord[k][ord_n[k]] = p;
                        ord_n[k]++;
                    end
                    rq_done[k][p] = 1'b1;
                end else if (rq_done[k][p]) begin
                    rq_done[k][p] = 1'b0;
                    if (auto_req && (immed[p] || $urandom_range(1) == 1)) new_req(k, p);
                    else pv[k][p] = 1'b0;
                end else if (auto_req && !pv[k][p] && int'($urandom_range(99)) < req_pct[p]) begin
                    new_req(k, p);
                end
            end
        end
        if (rst_pct > 0) reset = (int'($urandom_range(99)) < rst_pct);
    endtask

    task automatic drain();
        bit quiet;
        auto_req = 0;
        quiet = 0;
        for (int i = 0; i < 200 && !quiet; i++) begin
            step();
            quiet = !(pv[0][0] || pv[0][1] || pv[1][0] || pv[1][1] || bsy[0] || bsy[1]);
        end
        chk("drain", quiet, 1);
    endtask

    task automatic do_req(input int p, input logic w, input logic [31:0] a, input logic [127:0] d);
        int  base [2];
        bit  done;
        for (int k = 0; k < 2; k++) begin
            pv[k][p] = 1'b1;
            pa[k][p] = a;
            pw[k][p] = w;
            pd[k][p] = d;
            base[k]  = ready_cnt[k][p];
        end
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            step();
            done = (ready_cnt[0][p] > base[0]) && (ready_cnt[1][p] > base[1]);
        end
        chk($sformatf("p%0d_req_done", p), done, 1);
        step();
        step();
    endtask

    initial begin
        int  base [2];
        bit  ok;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mv[k] = 1'b0;
            mr[k] = 1'b0;
            mrd[k] = '0;
            dly[k] = 0;
            ord_n[k] = 0;
            mdl_out[k] = 1'b0;
            mdl_resp[k] = 1'b0;
            mdl_last[k] = 1'b1;
            mdl_own[k] = 0;
            for (int i = 0; i < 64; i++) mem[k][i] = rnd128();
            for (int p = 0; p < 2; p++) begin
                pv[k][p] = 1'b0;
                pa[k][p] = '0;
                pw[k][p] = 1'b0;
                pd[k][p] = '0;
                rq_done[k][p] = 1'b0;
                ready_cnt[k][p] = 0;
            end
        end
        step();

        // Both ports requesting continuously from reset.
        auto_req = 1;
        req_pct  = '{100, 100};
        immed    = '{1, 1};
        for (int k = 0; k < 2; k++) for (int p = 0; p < 2; p++) new_req(k, p);
        step();
        reset = 1'b0;
        ord_n = '{0, 0};
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step();
            ok = (ord_n[0] >= 4) && (ord_n[1] >= 4);
        end
        chk("order_wait", ok, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr1.order%0d", i), ord[1][i], i % 2);
            chk($sformatf("rr0.order%0d", i), ord[0][i], 0);
        end
        chk("rr0.p1_starved", ready_cnt[0][1], 0);

        // Port 0 goes quiet: port 1 must get in on the fixed-priority instance.
        req_pct[0] = 0;
        immed[0]   = 0;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            ok = ready_cnt[0][1] >= 1;
        end
        chk("rr0.p1_served", ok, 1);
        drain();

        // Single read with a fixed 3-cycle controller delay.
        dly_min = 3;
        dly_max = 3;
        for (int k = 0; k < 2; k++) begin
            mem[k][16] = 128'h5;
            base[k] = ready_cnt[k][1];
        end
        do_req(0, 1'b0, 32'h100, '0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rr%0d.read_data", k), prd[k][0], 128'h5);
            chk($sformatf("rr%0d.p1_idle", k), ready_cnt[k][1] - base[k], 0);
        end

        // Write then read back on port 1.
        dly_min = 0;
        dly_max = 4;
        do_req(1, 1'b1, 32'h100, 128'h1);
        do_req(1, 1'b0, 32'h100, '0);
        for (int k = 0; k < 2; k++) chk($sformatf("rr%0d.readback", k), prd[k][1], 128'h1);

        // Stray m_ready with nothing pending.
        stray_pct = 100;
        repeat (4) step();
        stray_pct = 0;
        for (int k = 0; k < 2; k++) chk($sformatf("rr%0d.stray_rdata", k), prd[k][1], 128'h1);
        step();

        // Reset while the controller request is outstanding.
        dly_min = 10;
        dly_max = 10;
        for (int k = 0; k < 2; k++) begin
            pv[k][0] = 1'b1;
            pa[k][0] = 32'h40;
            pw[k][0] = 1'b0;
            pd[k][0] = '0;
            base[k]  = ready_cnt[k][0];
        end
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            ok = mv[0] && mv[1];
        end
        chk("issue_seen", ok, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rr%0d.rst_m_valid", k), mv[k], 0);
            chk($sformatf("rr%0d.rst_busy", k), bsy[k], 0);
            chk($sformatf("rr%0d.rst_ready", k), pr[k][0] | pr[k][1], 0);
        end
        dly_min = 0;
        dly_max = 5;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            ok = (ready_cnt[0][0] > base[0]) && (ready_cnt[1][0] > base[1]);
        end
        chk("post_reset_served", ok, 1);
        for (int k = 0; k < 2; k++) chk($sformatf("rr%0d.post_reset_once", k), ready_cnt[k][0] - base[k], 1);
        drain();

        // Randomized traffic with stray m_ready and occasional resets.
        auto_req  = 1;
        req_pct   = '{40, 40};
        immed     = '{0, 0};
        stray_pct = 10;
        rst_pct   = 1;
        repeat (3000) step();
        rst_pct   = 0;
        reset     = 1'b0;
        stray_pct = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
